// File: rtl/pdm_modulator_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pdm_modulator_pkg : shared audio PCM format constants and helpers |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package pdm_modulator_pkg;

  localparam int                        c_pcm_width  = 8;
  localparam logic [c_pcm_width-1:0]    c_pcm_offset = 8'd128;

  typedef logic signed [c_pcm_width-1:0] pcm_t;
  typedef logic        [c_pcm_width-1:0] upcm_t;

  // Offset-binary view of a signed sample: -128..127 maps to 0..255.
  function automatic upcm_t pcm_to_unsigned(input pcm_t s);
    upcm_t raw;
    raw = s;
    return raw + c_pcm_offset;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_modulator_sample_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sample_fifo : synchronous PCM sample FIFO with registered count   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sample_fifo
  import pdm_modulator_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = c_pcm_width
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == (c_aw+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign level    = r_count;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pdm_modulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pdm_modulator : first-order sigma-delta PCM to 1-bit PDM encoder  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module pdm_modulator
  import pdm_modulator_pkg::*;
#(
  parameter int CLK_DIV    = 100,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          s_valid,
  input  logic [c_pcm_width-1:0]        s_data,
  output logic                          s_ready,
  output logic                          pdm_out,
  output logic                          bit_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_div_w = $clog2(CLK_DIV);
  localparam int c_bit_w = $clog2(OSR);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(OSR - 1);

  logic [c_div_w-1:0]     r_div;
  logic [c_bit_w-1:0]     r_bit;
  upcm_t                  r_acc;
  pcm_t                   r_cur;
  logic                   r_pdm;
  logic                   r_tick;
  logic                   r_underrun;

  logic                   w_step;
  logic                   w_fetch;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [c_pcm_width-1:0] w_head;
  pcm_t                   w_sample;
  upcm_t                  w_u;
  logic [c_pcm_width:0]   w_sum;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_pcm_width)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (w_fetch),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .level     (fifo_level)
  );

  assign s_ready  = !w_fifo_full;
  assign w_step   = enable && (r_div == c_div_last);
  assign w_fetch  = w_step && (r_bit == '0);

  // The fetched sample feeds the same step's sum; an empty FIFO yields silence.
  assign w_sample = w_fetch ? (w_fifo_empty ? pcm_t'(0) : pcm_t'(w_head)) : r_cur;
  assign w_u      = pcm_to_unsigned(w_sample);
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_bit      <= '0;
      r_acc      <= '0;
      r_cur      <= '0;
      r_pdm      <= 1'b0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!enable) begin
      r_div      <= '0;
      r_bit      <= '0;
      r_acc      <= '0;
      r_pdm      <= 1'b0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_div      <= w_step ? '0 : r_div + 1'b1;
      r_tick     <= w_step;
      r_underrun <= w_fetch && w_fifo_empty;
      if (w_step) begin
        r_bit <= (r_bit == c_bit_last) ? '0 : r_bit + 1'b1;
        r_acc <= w_sum[c_pcm_width-1:0];
        r_pdm <= w_sum[c_pcm_width];
      end
      if (w_fetch) begin
        r_cur <= w_sample;
      end
    end
  end

  assign pdm_out  = r_pdm;
  assign bit_tick = r_tick;
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pdm_modulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pdm_modulator : directed bench for pdm_modulator               |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_pdm_modulator;

  localparam int CLK_DIV = 4;
  localparam int OSR     = 16;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       pdm_out;
  logic       bit_tick;
  logic       underrun;
  logic [2:0] fifo_level;

  pdm_modulator #(
    .CLK_DIV    (CLK_DIV),
    .OSR        (OSR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .pdm_out    (pdm_out),
    .bit_tick   (bit_tick),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int ucnt    = 0;
  int prev_level = 0;
  bit q_bits[$];
  int q_tick[$];
  int q_drop[$];

  // Record every PDM bit, its cycle, underrun pulses and FIFO level drops.
  always @(negedge clk) begin
    cyc++;
    if (bit_tick) begin
      q_bits.push_back(pdm_out);
      q_tick.push_back(cyc);
    end
    if (underrun) ucnt++;
    if (int'(fifo_level) < prev_level) q_drop.push_back(cyc);
    prev_level = int'(fifo_level);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    s_valid = 1'b1;
    s_data  = v;
    step_cyc(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (q_bits.size() < n && t < 3000) begin
      step_cyc(1);
      t++;
    end
    chk("bits_timeout", 32'(q_bits.size() >= n), 1);
  endtask

  task automatic clear_q();
    q_bits.delete();
    q_tick.delete();
    q_drop.delete();
  endtask

  function automatic int ones(input int start);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(q_bits[start+i]);
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    int c0, bad_gaps, ubase;
    int exp_b [3];

    // Reset values
    #1;
    chk("rst_pdm", pdm_out, 0);
    chk("rst_tick", bit_tick, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", s_ready, 1);
    step_cyc(2);
    rst_n = 1'b1;
    step_cyc(1);

    // Sample 0 -> alternating 0,1 with a tick every CLK_DIV cycles
    push(8'h00);
    chk("a_level_prefill", fifo_level, 1);
    clear_q();
    c0 = cyc;
    enable = 1'b1;
    wait_bits(16);
    enable = 1'b0;
    for (int i = 0; i < 16; i++) pat[i] = q_bits[i];
    chk("a_pattern", pat, 16'hAAAA);
    chk("a_first_tick", q_tick[0] - c0, 4);
    bad_gaps = 0;
    for (int i = 1; i < 16; i++) if (q_tick[i] - q_tick[i-1] != 4) bad_gaps++;
    chk("a_tick_gaps", bad_gaps, 0);
    chk("a_level_after", fifo_level, 0);
    chk("a_underrun", ucnt, 0);
    step_cyc(1);

    // Extremes and mid value, accumulator cleared by enable toggle
    push(8'h7F);
    push(8'h80);
    push(8'h40);
    chk("b_level", fifo_level, 3);
    exp_b[0] = 15; exp_b[1] = 0; exp_b[2] = 12;
    for (int k = 0; k < 3; k++) begin
      clear_q();
      enable = 1'b1;
      wait_bits(16);
      enable = 1'b0;
      chk($sformatf("b_ones_%0d", k), ones(0), exp_b[k]);
      step_cyc(1);
    end
    chk("b_level_after", fifo_level, 0);
    chk("b_underrun", ucnt, 0);

    // Full FIFO, rejected fifth sample, pop spacing, then underrun periods
    push(8'hC0);
    push(8'h00);
    push(8'h40);
    push(8'h80);
    chk("c_level_full", fifo_level, 4);
    chk("c_ready_full", s_ready, 0);
    push(8'h70);
    chk("c_level_reject", fifo_level, 4);
    clear_q();
    ubase = ucnt;
    enable = 1'b1;
    wait_bits(64);
    chk("c_ones_0", ones(0), 4);
    chk("c_ones_1", ones(16), 8);
    chk("c_ones_2", ones(32), 12);
    chk("c_ones_3", ones(48), 0);
    chk("c_pop_gap_1", q_drop[1] - q_drop[0], 64);
    chk("c_pop_gap_2", q_drop[2] - q_drop[1], 64);
    chk("c_pop_gap_3", q_drop[3] - q_drop[2], 64);
    chk("c_no_underrun_yet", ucnt - ubase, 0);
    wait_bits(80);
    chk("c_empty_ones_0", ones(64), 8);
    chk("c_underrun_1", ucnt - ubase, 1);
    wait_bits(96);
    chk("c_empty_ones_1", ones(80), 8);
    chk("c_underrun_2", ucnt - ubase, 2);
    enable = 1'b0;
    step_cyc(1);

    // Push landing on the same edge as a fetch at level 2
    push(8'h40);
    push(8'hC0);
    chk("d_level_pre", fifo_level, 2);
    clear_q();
    ubase = ucnt;
    enable = 1'b1;
    step_cyc(3);
    s_valid = 1'b1;
    s_data  = 8'h00;
    step_cyc(1);
    s_valid = 1'b0;
    chk("d_level_pushpop", fifo_level, 2);
    wait_bits(48);
    enable = 1'b0;
    chk("d_ones_0", ones(0), 12);
    chk("d_ones_1", ones(16), 4);
    chk("d_ones_2", ones(32), 8);
    chk("d_underrun", ucnt - ubase, 0);
    step_cyc(1);

    // Asynchronous reset mid-sample with three samples queued
    push(8'h7F);
    push(8'h7F);
    push(8'h7F);
    push(8'h7F);
    enable = 1'b1;
    step_cyc(20);
    chk("e_level_pre", fifo_level, 3);
    chk("e_pdm_pre", pdm_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_level_rst", fifo_level, 0);
    chk("e_pdm_rst", pdm_out, 0);
    chk("e_ready_rst", s_ready, 1);
    enable = 1'b0;
    step_cyc(2);
    rst_n = 1'b1;
    step_cyc(2);
    chk("e_level_post", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
